// File: rtl/weighted_sum_neuron.sv
// weighted_sum_neuron: captures 8 weights and 8 input lanes on a valid/ready
// handshake. It then accumulates their unsigned dot product with one MAC per
// cycle, using saturating arithmetic. The result and a threshold spike are
// presented on a valid/ready output port.
// Optional build macro NEURON_LEAK_EN: the accumulator persists between samples
// as a leaky membrane potential instead of clearing at each capture.
module weighted_sum_neuron #(
  parameter int unsigned WIDTH_P     = 4,
  parameter int unsigned IN_WIDTH_P  = 4,
  parameter int unsigned ACC_WIDTH_P = 12,
  parameter int unsigned THRESH_P    = 200
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [WIDTH_P-1:0]      weight_0,
  input  logic [WIDTH_P-1:0]      weight_1,
  input  logic [WIDTH_P-1:0]      weight_2,
  input  logic [WIDTH_P-1:0]      weight_3,
  input  logic [WIDTH_P-1:0]      weight_4,
  input  logic [WIDTH_P-1:0]      weight_5,
  input  logic [WIDTH_P-1:0]      weight_6,
  input  logic [WIDTH_P-1:0]      weight_7,
  input  logic [8*IN_WIDTH_P-1:0] x_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [ACC_WIDTH_P-1:0]  sum_o,
  output logic                    spike_o,
  output logic                    valid_o,
  input  logic                    ready_i
);

  localparam int unsigned PROD_W = WIDTH_P + IN_WIDTH_P;
  localparam int unsigned SUM_W  = ((ACC_WIDTH_P > PROD_W) ? ACC_WIDTH_P : PROD_W) + 1;
  localparam logic [ACC_WIDTH_P-1:0] ACC_MAX  = {ACC_WIDTH_P{1'b1}};
  localparam logic [ACC_WIDTH_P-1:0] THRESH_C = ACC_WIDTH_P'(THRESH_P);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_e;

  state_e                          state_q, state_d;
  logic [2:0]                      idx_q, idx_d;
  logic [ACC_WIDTH_P-1:0]          acc_q, acc_d;
  logic [ACC_WIDTH_P-1:0]          sum_q, sum_d;
  logic                            spike_q, spike_d;
  logic [7:0][WIDTH_P-1:0]         w_q, w_d;
  logic [7:0][IN_WIDTH_P-1:0]      x_q, x_d;

  logic [PROD_W-1:0]               prod;
  logic [SUM_W-1:0]                sum_wide;
  logic [ACC_WIDTH_P-1:0]          acc_next;

  // Saturating MAC on the lane selected by idx
  always_comb begin
    prod     = PROD_W'(w_q[idx_q]) * PROD_W'(x_q[idx_q]);
    sum_wide = SUM_W'(acc_q) + SUM_W'(prod);
    acc_next = (sum_wide > SUM_W'(ACC_MAX)) ? ACC_MAX : sum_wide[ACC_WIDTH_P-1:0];
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    spike_d = spike_q;
    w_d     = w_q;
    x_d     = x_q;
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          w_d   = {weight_7, weight_6, weight_5, weight_4,
                   weight_3, weight_2, weight_1, weight_0};
          x_d   = x_i;
          idx_d = 3'd0;
`ifdef NEURON_LEAK_EN
          acc_d = spike_q ? '0 : (acc_q >> 1);
`else
          acc_d = '0;
`endif
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_next;
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          sum_d   = acc_next;
          spike_d = (acc_next >= THRESH_C);
          state_d = OUT;
        end
      end
      OUT: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      spike_q <= 1'b0;
      w_q     <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      spike_q <= spike_d;
      w_q     <= w_d;
      x_q     <= x_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == OUT);
  assign sum_o   = sum_q;
  assign spike_o = spike_q;

endmodule
